matrix_op_sequencer: RTL

- Controller that queues 15-bit coprocessor instructions and sequences the shared matrix ALU and the matrix memory.
- Decides when memory is read, when each operand register loads, when the ALU result is captured and when it is written back.
- Sits between the host instruction source and the datapath; the datapath keeps operand/result registers and takes this block's strobes.

---
 rtl/matrix_op_sequencer_pkg.sv | 29 ++
 rtl/matrix_op_sequencer_fifo.sv | 53 +++++
 rtl/matrix_op_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/matrix_op_sequencer_pkg.sv
// Shared definitions for the matrix coprocessor sequencer: instruction field
// layout, opcode and size limits, and the FSM state encoding.
package coproc_seq_pkg;

  localparam int INSTR_W  = 15;
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 3;
  localparam int SIZE_LSB = 3;
  localparam int SIZE_W   = 3;
  localparam int ADDR_LSB = 6;
  localparam int ADDR_W   = 8;
  localparam int SEL_LSB  = 14;
  localparam int SEL_W    = 1;

  localparam logic [OPC_W-1:0]  OP_LOAD  = 3'b000;
  localparam logic [SIZE_W-1:0] MAX_SIZE = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    RD_WAIT,
    LATCH,
    ALU_WAIT,
    CAPTURE,
    WB,
    REJECT
  } seq_state_t;

endpackage

// File: rtl/matrix_op_sequencer_fifo.sv
// Synchronous instruction queue with first-word-fall-through read data;
// pushes while full and pops while empty are ignored.
module seq_instr_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Queues coprocessor instructions and sequences memory reads, operand loads,
// ALU capture and writeback. Optional macro OPERAND_CHECK_EN rejects operations issued before both operands are loaded.
module matrix_op_sequencer
  import coproc_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_RD_LAT = 1,
  parameter int ALU_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [INSTR_W-1:0]   instr_data,
  output logic                 instr_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_wren,
  output logic                 load_a_en,
  output logic                 load_b_en,
  output logic                 result_en,
  output logic [OPC_W-1:0]     alu_opcode,
  output logic [SIZE_W-1:0]    alu_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          op_count
);

  seq_state_t                    state;
  logic [INSTR_W-1:0]            fifo_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_pop;
  logic                          cur_sel;
  logic [7:0]                    wait_cnt;
  logic                          reject_now;
`ifdef OPERAND_CHECK_EN
  logic                          a_loaded;
  logic                          b_loaded;
`endif

  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign instr_ready = !fifo_full;
  assign busy        = (state != IDLE) || (fifo_count != '0);

  seq_instr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (instr_valid),
    .push_data(instr_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // alu_opcode/alu_size double as the current-instruction fields once popped.
  always_comb begin
    reject_now = (alu_size > MAX_SIZE);
`ifdef OPERAND_CHECK_EN
    if ((alu_opcode != OP_LOAD) && !(a_loaded && b_loaded)) reject_now = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_sel    <= 1'b0;
      wait_cnt   <= '0;
      mem_addr   <= '0;
      alu_opcode <= '0;
      alu_size   <= '0;
      mem_wren   <= 1'b0;
      load_a_en  <= 1'b0;
      load_b_en  <= 1'b0;
      result_en  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      op_count   <= '0;
`ifdef OPERAND_CHECK_EN
      a_loaded   <= 1'b0;
      b_loaded   <= 1'b0;
`endif
    end else begin
      mem_wren  <= 1'b0;
      load_a_en <= 1'b0;
      load_b_en <= 1'b0;
      result_en <= 1'b0;
      done      <= 1'b0;
      // Strobes are registered on entry to their state so they line up with it.
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mem_addr   <= fifo_data[ADDR_LSB +: ADDR_W];
            alu_opcode <= fifo_data[OPC_LSB +: OPC_W];
            alu_size   <= fifo_data[SIZE_LSB +: SIZE_W];
            cur_sel    <= fifo_data[SEL_LSB];
            state      <= DECODE;
          end
        end
        DECODE: begin
          if (reject_now) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= REJECT;
          end else if (alu_opcode == OP_LOAD) begin
            wait_cnt <= 8'(MEM_RD_LAT - 1);
            state    <= RD_WAIT;
          end else begin
            wait_cnt <= 8'(ALU_LAT - 1);
            state    <= ALU_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            load_a_en <= !cur_sel;
            load_b_en <= cur_sel;
            done      <= 1'b1;
            op_count  <= op_count + 16'd1;
`ifdef OPERAND_CHECK_EN
            if (cur_sel) b_loaded <= 1'b1;
            else         a_loaded <= 1'b1;
`endif
            state     <= LATCH;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ALU_WAIT: begin
          if (wait_cnt == '0) begin
            result_en <= 1'b1;
            state     <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        CAPTURE: begin
          mem_wren <= 1'b1;
          done     <= 1'b1;
          op_count <= op_count + 16'd1;
          state    <= WB;
        end
        LATCH, WB, REJECT: state <= IDLE;
        default:           state <= IDLE;
      endcase
    end
  end

endmodule
